// File: rtl/x25519_mult_sequencer.sv
// X25519 multiply sequencer: issues 32 limb passes, collects limb sums, runs the two-round squeeze.
// Optional watchdog on the collect phase is enabled by defining X25519_MULT_WATCHDOG_EN.
module x25519_mult_sequencer #(
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a_in,
  input  logic [255:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [263:0] result,
  output logic         err,
  output logic         pass_en,
  output logic [4:0]   pass_i,
  output logic [263:0] pass_a,
  output logic [255:0] pass_b,
  input  logic         pass_out_valid,
  input  logic [31:0]  pass_out
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SQ1, SQ2, DONE} state_t;

  state_t        state;
  logic [255:0]  a_lat;
  logic [255:0]  b_lat;
  logic [4:0]    cnt;
  logic [4:0]    collect_cnt;
  logic [31:0]   u;
  logic [31:0]   w [32];
  logic [31:0]   sum;
  logic          collect;
  logic          last_word;

  assign sum       = u + w[cnt];
  assign collect   = pass_out_valid && (state == ISSUE || state == WAIT);
  assign last_word = collect && (collect_cnt == 5'd31);

  // Limb j of the permuted operand is b[(i - j) mod 32]; 5-bit wrap gives the mod.
  function automatic logic [255:0] permute_b(input logic [255:0] b, input logic [4:0] i);
    logic [255:0] r;
    logic [4:0]   k;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      k = i - 5'(j);
      r[8*j +: 8] = b[8*k +: 8];
    end
    return r;
  endfunction

`ifdef X25519_MULT_WATCHDOG_EN
  logic [15:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      pass_en     <= 1'b0;
      pass_i      <= '0;
      pass_a      <= '0;
      pass_b      <= '0;
      a_lat       <= '0;
      b_lat       <= '0;
      cnt         <= '0;
      collect_cnt <= '0;
      u           <= '0;
`ifdef X25519_MULT_WATCHDOG_EN
      err         <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef X25519_MULT_WATCHDOG_EN
      err  <= 1'b0;
`endif
      if (collect) collect_cnt <= collect_cnt + 5'd1;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat       <= a_in;
            b_lat       <= b_in;
            busy        <= 1'b1;
            cnt         <= '0;
            collect_cnt <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          pass_en <= 1'b1;
          pass_i  <= cnt;
          pass_a  <= {8'h00, a_lat};
          pass_b  <= permute_b(b_lat, cnt);
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= WAIT;
`ifdef X25519_MULT_WATCHDOG_EN
            wd_cnt <= 16'(WATCHDOG_CYCLES - 1);
`endif
          end
        end
        WAIT: begin
          pass_en <= 1'b0;
          if (last_word) begin
            u     <= '0;
            state <= SQ1;
`ifdef X25519_MULT_WATCHDOG_EN
            wd_cnt <= '0;
          end else if (wd_cnt == 16'd0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt - 16'd1;
`endif
          end
        end
        SQ1: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            u     <= (sum >> 7) * 32'd19;
            state <= SQ2;
          end else begin
            u <= sum >> 8;
          end
        end
        SQ2: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
          else u <= sum >> 8;
        end
        DONE: begin
          for (int k = 0; k < 31; k++) result[8*k +: 8] <= w[k][7:0];
          result[263:248] <= w[31][15:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word buffer: written by collection, then rewritten in place by the squeeze rounds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (collect) begin
        w[collect_cnt] <= pass_out;
      end else if (state == SQ1 || state == SQ2) begin
        if (cnt != 5'd31)      w[cnt] <= {24'h0, sum[7:0]};
        else if (state == SQ1) w[31]  <= {25'h0, sum[6:0]};
        else                   w[31]  <= {16'h0, sum[15:0]};
      end
    end
  end

endmodule

// File: tb/tb_x25519_mult_sequencer.sv
// Randomized bench for x25519_mult_sequencer with a pass-pipeline model and a NaCl-style reference.
// Watchdog scenario is exercised only when X25519_MULT_WATCHDOG_EN is defined.
module tb_x25519_mult_sequencer;
  localparam int R   = 3;      // register stages in the pipeline model
  localparam int LAT = R + 1;  // pass sampled by pipeline -> word sampled by the sequencer
  localparam int WD  = 64;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] a_in, b_in;
  logic         busy, done, err, pass_en, pass_out_valid;
  logic [263:0] result, pass_a;
  logic [255:0] pass_b;
  logic [4:0]   pass_i;
  logic [31:0]  pass_out;

  always #5 clk = ~clk;

  x25519_mult_sequencer #(.WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .err(err),
    .pass_en(pass_en), .pass_i(pass_i), .pass_a(pass_a), .pass_b(pass_b),
    .pass_out_valid(pass_out_valid), .pass_out(pass_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [263:0] got, input logic [263:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned limb(input logic [263:0] v, input int j);
    return int'(v[8*j +: 8]);
  endfunction

  // Pass pipeline model: limb sum of a[j]*pb[j], weighted by 38 where the product wraps past 2^256.
  function automatic logic [31:0] pass_sum(input logic [263:0] pa, input logic [255:0] pb,
                                           input logic [4:0] i);
    int unsigned s = 0;
    for (int j = 0; j < 32; j++)
      s += limb(pa, j) * limb({8'h00, pb}, j) * ((j > int'(i)) ? 38 : 1);
    return s;
  endfunction

  function automatic logic [255:0] exp_perm(input logic [255:0] b, input int i);
    logic [255:0] r = '0;
    for (int j = 0; j < 32; j++) r[8*j +: 8] = b[8*(((i - j) % 32 + 32) % 32) +: 8];
    return r;
  endfunction

  // Reference: schoolbook product with 38-fold, then two squeeze rounds.
  function automatic logic [263:0] ref_mult(input logic [255:0] a, input logic [255:0] b);
    longint unsigned t [32];
    longint unsigned u;
    logic [263:0] r = '0;
    for (int i = 0; i < 32; i++) begin
      u = 0;
      for (int j = 0; j <= i; j++) u += limb({8'h0, a}, j) * limb({8'h0, b}, i - j);
      for (int j = i + 1; j < 32; j++) u += 38 * limb({8'h0, a}, j) * limb({8'h0, b}, i + 32 - j);
      t[i] = u;
    end
    u = 0;
    for (int j = 0; j < 31; j++) begin u += t[j]; t[j] = u & 255; u >>= 8; end
    u += t[31]; t[31] = u & 127; u = 19 * (u >> 7);
    for (int j = 0; j < 31; j++) begin u += t[j]; t[j] = u & 255; u >>= 8; end
    t[31] = (u + t[31]) & 16'hFFFF;
    for (int j = 0; j < 31; j++) r[8*j +: 8] = t[j][7:0];
    r[263:248] = t[31][15:0];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Pipeline model and stray-beat injection.
  bit          pv [R];
  logic [31:0] pw [R];
  bit          stray_v = 1'b0;
  logic [31:0] stray_w = '0;
  bit          drop_last = 1'b0;

  assign pass_out_valid = pv[R-1] | stray_v;
  assign pass_out       = stray_v ? stray_w : pw[R-1];

  always @(posedge clk) begin
    pv[0] <= pass_en && !(drop_last && pass_i == 5'd31);
    pw[0] <= pass_sum(pass_a, pass_b, pass_i);
    for (int s = 1; s < R; s++) begin
      pv[s] <= pv[s-1];
      pw[s] <= pw[s-1];
    end
  end

  int           busy_cyc = 0;
  int           done_cnt = 0;
  int           iss = 0;
  logic [255:0] cur_a = '0, cur_b = '0;

  always @(posedge clk) begin
    if (busy === 1'b1) busy_cyc++;
    if (done === 1'b1) done_cnt++;
    if (pass_en === 1'b1) begin
      chk("pass_i", {259'h0, pass_i}, 264'(iss % 32));
      chk("pass_a", pass_a, {8'h00, cur_a});
      chk("pass_b", {8'h00, pass_b}, {8'h00, exp_perm(cur_b, iss)});
      iss++;
    end
  end

  task automatic begin_op(input logic [255:0] a, input logic [255:0] b);
    @(negedge clk);
    busy_cyc = 0; done_cnt = 0; iss = 0; cur_a = a; cur_b = b;
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = rnd256(); b_in = rnd256();
  endtask

  task automatic run_mult(input logic [255:0] a, input logic [255:0] b, input string tag,
                          input bit poke, output logic [263:0] res);
    bit got = 1'b0;
    begin_op(a, b);
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      start = poke && (c == 10 || c == 70);
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 264'(got), 264'd1);
    chk({tag, "_result"}, result, ref_mult(a, b));
    chk({tag, "_busy_cycles"}, 264'(busy_cyc), 264'(1 + 32 + LAT + 64));
    res = result;
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 264'(done_cnt), 264'd1);
    chk({tag, "_busy_low"}, 264'(busy), 264'd0);
    chk({tag, "_err_low"}, 264'(err), 264'd0);
  endtask

  logic [263:0] res, exp_c;
  logic [255:0] p25519, ones;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 264'(busy), 264'd0);
    chk("rst_done", 264'(done), 264'd0);
    chk("rst_err", 264'(err), 264'd0);
    chk("rst_result", result, 264'd0);
    chk("rst_pass_en", 264'(pass_en), 264'd0);
    chk("rst_pass_i", 264'(pass_i), 264'd0);
    chk("rst_pass_a", pass_a, 264'd0);
    chk("rst_pass_b", 264'(pass_b), 264'd0);

    // Abort during ISSUE (beats still in flight), then during SQ1.
    begin_op(rnd256(), rnd256());
    repeat (20) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_issue_busy", 264'(busy), 264'd0);
    chk("abort_issue_result", result, 264'd0);
    begin_op(rnd256(), rnd256());
    repeat (40 + R) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_sq1_busy", 264'(busy), 264'd0);
    chk("abort_sq1_done", 264'(done_cnt), 264'd0);
    chk("abort_sq1_result", result, 264'd0);

    // Stray beats while idle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); stray_v = 1'b1; stray_w = $urandom;
    end
    @(negedge clk); stray_v = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_busy", 264'(busy), 264'd0);
    chk("stray_done", 264'(done_cnt), 264'd0);
    chk("stray_result", result, 264'd0);

    run_mult(256'd1, 256'd1, "one_x_one_poke", 1'b1, res);
    chk("one_x_one_value", res, 264'd1);

    run_mult(256'd1 << 128, 256'd1 << 128, "two128", 1'b0, res);
    chk("two128_value", res, 264'h26);

    p25519 = '1; p25519[255] = 1'b0; p25519[7:0] = 8'hED;
    run_mult(p25519, 256'd1, "p_x_one", 1'b0, res);
    exp_c = '1; exp_c[7:0] = 8'hED; exp_c[263:248] = 16'h007F;
    chk("p_x_one_value", res, exp_c);

    ones = '1;
    run_mult(ones, ones, "ones", 1'b0, res);

    for (int n = 0; n < 200; n++) run_mult(rnd256(), rnd256(), "random", 1'b0, res);

`ifdef X25519_MULT_WATCHDOG_EN
    begin
      bit got_err = 1'b0;
      drop_last = 1'b1;
      begin_op(rnd256(), rnd256());
      for (int c = 0; c < 300 && !got_err; c++) begin
        @(negedge clk);
        if (err === 1'b1) got_err = 1'b1;
      end
      chk("wd_err_seen", 264'(got_err), 264'd1);
      chk("wd_err_time", 264'(busy_cyc), 264'(32 + WD));
      chk("wd_busy_low", 264'(busy), 264'd0);
      repeat (5) @(negedge clk);
      drop_last = 1'b0;
      chk("wd_no_done", 264'(done_cnt), 264'd0);
      chk("wd_result_kept", result, res);
      run_mult(rnd256(), rnd256(), "after_wd", 1'b0, res);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
